// File: rtl/mdu_busy_unit_pkg.sv
// mdu_busy_unit_pkg: MDU opcodes, FSM states and default cycle counts (MDU_MADD_EN enables the accumulate ops)
package mdu_pkg;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/mdu_busy_unit_if.sv
// mdu_busy_unit_if: E-stage issue bus into the MDU and busy/HI/LO back out
interface mdu_busy_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        int_cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, mdu_op, rs_data, rt_data, int_cancel, input busy, hi, lo);
  modport slave (input start, mdu_op, rs_data, rt_data, int_cancel, output busy, hi, lo);
endinterface

// File: rtl/mdu_busy_unit_arith.sv
// mdu_arith: combinational multiply/divide (and accumulate when MDU_MADD_EN) result plus divide-by-zero flag
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
`ifdef MDU_MADD_EN
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
`endif
  output logic [63:0] res_o,
  output logic        dz_o
);
  logic        sgn;
  logic [63:0] a, b, prod;
  logic [31:0] rt_nz, sq, sr, uq, ur;
  assign sgn = op_i == OP_MULT || op_i == OP_DIV || op_i == OP_MADD || op_i == OP_MSUB;
  assign a = {{32{sgn & rs_i[31]}}, rs_i};
  assign b = {{32{sgn & rt_i[31]}}, rt_i};
  assign prod = a * b;
  assign dz_o = (op_i == OP_DIV || op_i == OP_DIVU) && rt_i == 32'd0;
  // A zero divisor is replaced by one so the dividers never see it; the result is discarded anyway
  assign rt_nz = rt_i == 32'd0 ? 32'd1 : rt_i;
  assign sq = $signed(rs_i) / $signed(rt_nz);
  assign sr = $signed(rs_i) % $signed(rt_nz);
  assign uq = rs_i / rt_nz;
  assign ur = rs_i % rt_nz;
  // Select the 64-bit {hi,lo} candidate for the op
  always_comb begin
    res_o = op_i == OP_DIV ? {sr, sq} :
            op_i == OP_DIVU ? {ur, uq} :
`ifdef MDU_MADD_EN
            (op_i == OP_MADD || op_i == OP_MADDU) ? {hi_i, lo_i} + prod :
            (op_i == OP_MSUB || op_i == OP_MSUBU) ? {hi_i, lo_i} - prod :
`endif
            prod;
  end
endmodule

// File: rtl/mdu_busy_unit.sv
// mdu_busy_unit: multi-cycle MDU owning HI/LO and driving busy to the stall controller (MDU_MADD_EN adds madd/msub)
module mdu_busy_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic             clk,
  input logic             reset,
  mdu_busy_unit_if.slave  bus
);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, dz_q, dz_d, dz, is_long, is_div, issue;
  logic [63:0] temp_q, temp_d, res;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  mdu_arith u_arith (
    .op_i (bus.mdu_op),
    .rs_i (bus.rs_data),
    .rt_i (bus.rt_data),
`ifdef MDU_MADD_EN
    .hi_i (hi_q),
    .lo_i (lo_q),
`endif
    .res_o(res),
    .dz_o (dz)
  );
  assign is_div = bus.mdu_op == OP_DIV || bus.mdu_op == OP_DIVU;
`ifdef MDU_MADD_EN
  assign is_long = (bus.mdu_op >= OP_MULT && bus.mdu_op <= OP_DIVU) ||
                   (bus.mdu_op >= OP_MADD && bus.mdu_op <= OP_MSUBU);
`else
  assign is_long = bus.mdu_op >= OP_MULT && bus.mdu_op <= OP_DIVU;
`endif
  assign issue = state_q == IDLE && bus.start && !bus.int_cancel;
  assign bus.busy = busy_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  // State, counter, latched result and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      temp_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dz_q    <= dz_d;
      temp_q  <= temp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  // Issue in IDLE, count down in RUN, commit the latched result on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dz_d    = dz_q;
    temp_d  = temp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (issue && is_long) begin
        state_d = RUN;
        cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        busy_d  = 1'b1;
        dz_d    = dz;
        temp_d  = res;
      end
      hi_d = issue && bus.mdu_op == OP_MTHI ? bus.rs_data : hi_q;
      lo_d = issue && bus.mdu_op == OP_MTLO ? bus.rs_data : lo_q;
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        hi_d    = dz_q ? hi_q : temp_q[63:32];
        lo_d    = dz_q ? lo_q : temp_q[31:0];
      end
    end
  end
endmodule

// File: tb/tb_mdu_busy_unit.sv
// tb_mdu_busy_unit: directed self-checking bench for mdu_busy_unit (accumulate checks when MDU_MADD_EN)
module tb_mdu_busy_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int n;
  mdu_busy_unit_if bus ();
  mdu_busy_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic cancel);
    bus.start = 1'b1;
    bus.mdu_op = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.int_cancel = cancel;
    tick();
    bus.start = 1'b0;
    bus.mdu_op = 4'd0;
    bus.int_cancel = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mdu_op = 4'd0;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    bus.int_cancel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);

    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFA);

    issue(4'd4, 32'd7, 32'd2, 1'b0);
    wait_idle(n);
    chk("divu_cycles", n, 32'd10);
    chk("divu_lo", bus.lo, 32'd3);
    chk("divu_hi", bus.hi, 32'd1);

    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);

    issue(4'd5, 32'h11, 32'd0, 1'b0);
    chk("mthi_hi", bus.hi, 32'h11);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(4'd6, 32'h22, 32'd0, 1'b0);
    chk("mtlo_lo", bus.lo, 32'h22);

    issue(4'd3, 32'd5, 32'd0, 1'b0);
    chk("dz_busy_rise", {31'd0, bus.busy}, 32'd1);
    issue(4'd5, 32'hDEAD, 32'd0, 1'b0);
    wait_idle(n);
    chk("dz_cycles_rest", n, 32'd9);
    chk("dz_hi", bus.hi, 32'h11);
    chk("dz_lo", bus.lo, 32'h22);

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_hi", bus.hi, 32'h11);
    chk("cancel_lo", bus.lo, 32'h22);
    issue(4'd6, 32'h99, 32'd0, 1'b1);
    chk("cancel_mtlo", bus.lo, 32'h22);
    issue(4'd0, 32'h77, 32'h77, 1'b0);
    chk("none_busy", {31'd0, bus.busy}, 32'd0);
`ifndef MDU_MADD_EN
    issue(4'd7, 32'h77, 32'h77, 1'b0);
    chk("madd_off_busy", {31'd0, bus.busy}, 32'd0);
    chk("madd_off_lo", bus.lo, 32'h22);
`endif
    issue(4'd15, 32'h77, 32'h77, 1'b0);
    chk("undef_busy", {31'd0, bus.busy}, 32'd0);

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    bus.int_cancel = 1'b1;
    wait_idle(n);
    bus.int_cancel = 1'b0;
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_lo", bus.lo, 32'h00000001);

    issue(4'd1, 32'd2, 32'd3, 1'b0);
    tick();
    tick();
    chk("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    repeat (6) tick();
    chk("rst_no_late_lo", bus.lo, 32'd0);
    issue(4'd6, 32'h5, 32'd0, 1'b0);
    chk("rst_mtlo", bus.lo, 32'h5);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
    chk("maddu_cycles", n, 32'd5);
    chk("maddu_hi", bus.hi, 32'd1);
    chk("maddu_lo", bus.lo, 32'd0);
    issue(4'd9, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
    chk("msub_cycles", n, 32'd5);
    chk("msub_hi", bus.hi, 32'd0);
    chk("msub_lo", bus.lo, 32'hFFFFFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_busy_unit.md
Name: mdu_busy_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu and mthi/mtlo, and owns the HI/LO registers. It generates the `busy` signal that the hazard/stall controller consumes to freeze F/D and flush E. It is the producer end of the busy/stall interface.

Parameters:
MULT_CYCLES, 5, number of busy cycles for mult/multu/madd-family ops (1..15)
DIV_CYCLES, 10, number of busy cycles for div/divu (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; the E-stage instruction is an MDU op to issue
mdu_op  in  4  op code (mdu_pkg): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10
rs_data  in  32  forwarded GPR[rs] operand
rt_data  in  32  forwarded GPR[rt] operand
int_cancel  in  1  exception/interrupt taken this cycle; the E-stage instruction must not commit
busy  out  1  registered; high while an op is in flight
hi  out  32  HI register value
lo  out  32  LO register value

Behaviour:
- Reset: busy=0, hi=0, lo=0, state=IDLE, cnt=0, temp_hi/temp_lo=0.
- FSM states: IDLE and RUN.
- IDLE, start=1, int_cancel=0:
  - MULT: {temp_hi,temp_lo} = signed rs*rt, 64-bit product.
  - MULTU: {temp_hi,temp_lo} = unsigned rs*rt.
  - DIV: temp_lo = signed quotient, temp_hi = signed remainder; truncation toward zero, remainder takes the sign of the dividend.
  - DIVU: temp_lo = unsigned quotient, temp_hi = unsigned remainder.
  - For MULT/MULTU/DIV/DIVU: cnt loads MULT_CYCLES or DIV_CYCLES, state goes to RUN, busy=1 from the next cycle.
  - MTHI/MTLO: hi or lo = rs_data at that edge; no busy, state stays IDLE.
- RUN: cnt decrements each cycle. When cnt==1, at that edge: hi=temp_hi, lo=temp_lo, busy=0, state goes to IDLE.
  - busy is high for exactly N cycles.
  - New hi/lo values are visible in the cycle busy falls.
- Divide by zero (rt_data==0 on DIV/DIVU): the op still occupies DIV_CYCLES busy cycles, but hi/lo are left unchanged at completion.
- start while in RUN: ignored. The stall controller guarantees this does not occur; the bench checks that hi/lo are unaffected.
- int_cancel=1 with start=1: the op is dropped entirely (no state change, no busy, MTHI/MTLO not written).
- int_cancel during RUN: no effect. An issued op has already committed architecturally and finishes normally.
- mdu_op=NONE or an undefined code with start=1: no effect.
- Mid-operation reset: returns to the reset values on that edge; the pending result is discarded.
- hi/lo are combinational reads of the architectural registers; mfhi/mflo forwarding is handled outside this block.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are accepted. {hi,lo} +/- signed or unsigned rs*rt, using the current {hi,lo} as the accumulator sampled at the start edge. They take MULT_CYCLES busy cycles.
- Undefined: codes 7..10 are treated as NONE; the accumulate datapath is not synthesised.

Decomposition:
- mdu_pkg holds:
  - the mdu_op localparams (NONE..MSUBU);
  - the state encodings IDLE/RUN;
  - default cycle counts.
- One sub-module, mdu_arith: purely combinational. It produces the 64-bit {temp_hi,temp_lo} and a div_by_zero flag from op, rs, rt, hi, lo.
- FSM, counter and HI/LO registers stay in mdu_busy_unit.

Test Plan:
1. MULT rs=0xFFFFFFFE (-2), rt=3: busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. DIVU rs=7, rt=2: busy high 10 cycles; then lo=3, hi=1. DIV rs=-7, rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV rs=5, rt=0 with hi=0x11, lo=0x22 preloaded by MTHI/MTLO: busy for 10 cycles; hi/lo remain 0x11/0x22.
4. MULTU 0xFFFFFFFF*0xFFFFFFFF with int_cancel=1 in the start cycle: busy stays 0, hi/lo unchanged. Repeat without cancel: hi=0xFFFFFFFE, lo=0x00000001.
5. Reset asserted in the 3rd busy cycle of a MULT: on the next cycle busy=0, hi=lo=0; a fresh MTLO of 0x5 then gives lo=5.
6. With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU rs=1, rt=1; after 5 busy cycles hi=1, lo=0.
